// File: rtl/proc_control_unit.sv
// -----------------------------------------------------------------------------
// proc_control_unit
//
// Control FSM for the 16-bit multi-cycle processor datapath (R0-R7, A, G and a
// shared Bus). On Run in T0 it latches the instruction word from DIN into IR,
// then steps through T1..T3, driving register write enables, the Bus mux
// select and the ALU function. Done marks the final step of each instruction.
//
// Ports:
//   Clock   in   1   rising-edge clock (manual clock in the processor)
//   Reset   in   1   asynchronous, active-high reset
//   Run     in   1   start request, only looked at in T0
//   DIN     in   DW  instruction word, or immediate data for mvi during T1
//   GNZ     in   1   G register is nonzero (used by mvnz)
//   IR      out  DW  instruction register contents
//   Rin     out  8   one-hot write enable for R0-R7
//   Ain     out  1   load enable for A
//   Gin     out  1   load enable for G
//   AluOp   out  2   ALU function: 00 add, 01 sub, 10 and
//   BusSel  out  4   Bus select: 0-7 = R0-R7, 8 = G, 9 = DIN
//   Done    out  1   instruction completes this cycle
//
// Outputs are decoded combinationally from the current step, IR and GNZ so
// the datapath sees its enables in the same cycle the step is active.
// -----------------------------------------------------------------------------
module proc_control_unit #(
   parameter int DW = 16
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Run,
   input  logic [DW-1:0] DIN,
   input  logic          GNZ,
   output logic [DW-1:0] IR,
   output logic [7:0]    Rin,
   output logic          Ain,
   output logic          Gin,
   output logic [1:0]    AluOp,
   output logic [3:0]    BusSel,
   output logic          Done
);

   // Time steps of the multi-cycle sequence
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // Opcodes held in IR[DW-1:DW-3]
   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_MVNZ = 3'b101;

   // Bus select codes outside the register range
   localparam logic [3:0] SEL_G   = 4'd8;
   localparam logic [3:0] SEL_DIN = 4'd9;

   // ALU function codes
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;

   state_t          state_r;
   logic [DW-1:0]   ir_r;

   logic [2:0]      op_s;
   logic [2:0]      rx_s;
   logic [2:0]      ry_s;
   logic            is_alu_s;

   logic [7:0]      rin_s;
   logic            ain_s;
   logic            gin_s;
   logic [1:0]      alu_op_s;
   logic [3:0]      bus_sel_s;
   logic            done_s;

   // One-hot decode of a 3-bit register index into an 8-bit enable vector
   function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
      logic [7:0] oh;
      oh = 8'b0000_0001 << idx;
      return oh;
   endfunction

   // Bus select code for a register index (0-7 map straight through)
   function automatic logic [3:0] reg_sel(input logic [2:0] idx);
      return {1'b0, idx};
   endfunction

   // Instruction field extraction; the low bits of IR are don't-care
   assign op_s     = ir_r[DW-1:DW-3];
   assign rx_s     = ir_r[DW-4:DW-6];
   assign ry_s     = ir_r[DW-7:DW-9];
   assign is_alu_s = (op_s == OP_ADD) || (op_s == OP_SUB) || (op_s == OP_AND);

   // Step sequencing and instruction capture
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= T0;
         ir_r    <= '0;
      end else begin
         case (state_r)
            T0: begin
               // Run is only honoured here; otherwise IR holds its value
               if (Run) begin
                  ir_r    <= DIN;
                  state_r <= T1;
               end else begin
                  state_r <= T0;
               end
            end
            T1: begin
               if (is_alu_s) begin
                  state_r <= T2;
               end else begin
                  state_r <= T0;
               end
            end
            T2: begin
               // T2 is only reachable by ALU ops; anything else bails out
               if (is_alu_s) begin
                  state_r <= T3;
               end else begin
                  state_r <= T0;
               end
            end
            T3: begin
               state_r <= T0;
            end
            default: begin
               state_r <= T0;
            end
         endcase
      end
   end

   // Per-step control decode; every step starts from the idle defaults
   always_comb begin
      rin_s     = 8'b0000_0000;
      ain_s     = 1'b0;
      gin_s     = 1'b0;
      alu_op_s  = ALU_ADD;
      bus_sel_s = SEL_DIN;
      done_s    = 1'b0;

      case (state_r)
         T0: begin
            // Fetch step: nothing is enabled on the datapath
            done_s = 1'b0;
         end
         T1: begin
            case (op_s)
               OP_MV: begin
                  bus_sel_s = reg_sel(ry_s);
                  rin_s     = reg_onehot(rx_s);
                  done_s    = 1'b1;
               end
               OP_MVI: begin
                  // Immediate is taken from DIN in this very cycle
                  bus_sel_s = SEL_DIN;
                  rin_s     = reg_onehot(rx_s);
                  done_s    = 1'b1;
               end
               OP_MVNZ: begin
                  bus_sel_s = reg_sel(ry_s);
                  if (GNZ) begin
                     rin_s = reg_onehot(rx_s);
                  end else begin
                     rin_s = 8'b0000_0000;
                  end
                  done_s    = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  bus_sel_s = reg_sel(rx_s);
                  ain_s     = 1'b1;
               end
               default: begin
                  // Reserved opcodes retire as a NOP
                  done_s = 1'b1;
               end
            endcase
         end
         T2: begin
            if (is_alu_s) begin
               bus_sel_s = reg_sel(ry_s);
               gin_s     = 1'b1;
               case (op_s)
                  OP_SUB:  alu_op_s = ALU_SUB;
                  OP_AND:  alu_op_s = ALU_AND;
                  default: alu_op_s = ALU_ADD;
               endcase
            end else begin
               bus_sel_s = SEL_DIN;
            end
         end
         T3: begin
            if (is_alu_s) begin
               bus_sel_s = SEL_G;
               rin_s     = reg_onehot(rx_s);
               done_s    = 1'b1;
            end else begin
               bus_sel_s = SEL_DIN;
            end
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   assign IR     = ir_r;
   assign Rin    = rin_s;
   assign Ain    = ain_s;
   assign Gin    = gin_s;
   assign AluOp  = alu_op_s;
   assign BusSel = bus_sel_s;
   assign Done   = done_s;

endmodule

// File: tb/tb_proc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_proc_control_unit
//
// Table-driven bench for proc_control_unit. Each table row is one clock cycle:
// inputs are applied on the falling edge, the expected output bundle is pushed
// to a scoreboard queue, and one time unit later it is popped and compared
// against the combinational outputs. Hand-written sequences cover reset in the
// middle of an ALU op and the latency of a sub instruction.
// -----------------------------------------------------------------------------
module tb_proc_control_unit;

   logic        Clock;
   logic        Reset;
   logic        Run;
   logic [15:0] DIN;
   logic        GNZ;
   logic [15:0] IR;
   logic [7:0]  Rin;
   logic        Ain;
   logic        Gin;
   logic [1:0]  AluOp;
   logic [3:0]  BusSel;
   logic        Done;

   typedef struct packed {
      logic        run;
      logic [15:0] din;
      logic        gnz;
      logic [15:0] ir;
      logic [7:0]  rin;
      logic        ain;
      logic        gin;
      logic [1:0]  aop;
      logic [3:0]  bs;
      logic        done;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   proc_control_unit #(.DW(16)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Run    (Run),
      .DIN    (DIN),
      .GNZ    (GNZ),
      .IR     (IR),
      .Rin    (Rin),
      .Ain    (Ain),
      .Gin    (Gin),
      .AluOp  (AluOp),
      .BusSel (BusSel),
      .Done   (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic void add_vec(input logic run, input logic [15:0] din,
                                   input logic gnz, input logic [15:0] ir,
                                   input logic [7:0] rin, input logic ain,
                                   input logic gin, input logic [1:0] aop,
                                   input logic [3:0] bs, input logic done);
      vec_t v;
      v.run = run; v.din = din; v.gnz = gnz; v.ir = ir; v.rin = rin;
      v.ain = ain; v.gin = gin; v.aop = aop; v.bs = bs; v.done = done;
      tbl.push_back(v);
   endfunction

   // Pop the oldest expectation and compare it with the live outputs
   task automatic check_outputs(input string name);
      vec_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = exp_q.pop_front();
      if (IR === e.ir && Rin === e.rin && Ain === e.ain && Gin === e.gin &&
          AluOp === e.aop && BusSel === e.bs && Done === e.done) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got IR=%h Rin=%b Ain=%b Gin=%b AluOp=%b BusSel=%0d Done=%b, expected IR=%h Rin=%b Ain=%b Gin=%b AluOp=%b BusSel=%0d Done=%b",
                  name, IR, Rin, Ain, Gin, AluOp, BusSel, Done,
                  e.ir, e.rin, e.ain, e.gin, e.aop, e.bs, e.done);
      end
   endtask

   // Drive one cycle of stimulus on the falling edge and check it
   task automatic apply(input vec_t v, input string name);
      @(negedge Clock);
      Run = v.run;
      DIN = v.din;
      GNZ = v.gnz;
      exp_q.push_back(v);
      #1;
      check_outputs(name);
   endtask

   // Expected idle outputs with a given IR
   function automatic vec_t idle(input logic run, input logic [15:0] din,
                                 input logic [15:0] ir);
      vec_t v;
      v.run = run; v.din = din; v.gnz = 1'b0; v.ir = ir; v.rin = 8'h00;
      v.ain = 1'b0; v.gin = 1'b0; v.aop = 2'b00; v.bs = 4'd9; v.done = 1'b0;
      return v;
   endfunction

   initial begin
      int cyc;
      bit seen;

      Reset = 1'b1;
      Run   = 1'b0;
      DIN   = 16'h0000;
      GNZ   = 1'b0;

      //      run   din        gnz   ir         rin           ain   gin   aop    bs    done
      // idle after reset
      add_vec(1'b0, 16'h0000, 1'b0, 16'h0000, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      // mvi R1, immediate 5 presented in T1
      add_vec(1'b1, 16'h2400, 1'b0, 16'h0000, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b0, 16'h0005, 1'b0, 16'h2400, 8'b0000_0010, 1'b0, 1'b0, 2'b00, 4'd9, 1'b1);
      add_vec(1'b0, 16'h0005, 1'b0, 16'h2400, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      // add R2,R1
      add_vec(1'b1, 16'h4880, 1'b0, 16'h2400, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b0, 16'h1234, 1'b0, 16'h4880, 8'b0000_0000, 1'b1, 1'b0, 2'b00, 4'd2, 1'b0);
      add_vec(1'b0, 16'h1234, 1'b0, 16'h4880, 8'b0000_0000, 1'b0, 1'b1, 2'b00, 4'd1, 1'b0);
      add_vec(1'b0, 16'h1234, 1'b0, 16'h4880, 8'b0000_0100, 1'b0, 1'b0, 2'b00, 4'd8, 1'b1);
      // mvnz R0,R1 with GNZ=0 then GNZ=1
      add_vec(1'b1, 16'hA080, 1'b0, 16'h4880, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b0, 16'h0000, 1'b0, 16'hA080, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
      add_vec(1'b1, 16'hA080, 1'b1, 16'hA080, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b0, 16'h0000, 1'b1, 16'hA080, 8'b0000_0001, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
      // Run held high: mv R0,R1 then sub R3,R0 then mv again, no lost fetch
      add_vec(1'b1, 16'h0080, 1'b1, 16'hA080, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b1, 16'h6C00, 1'b1, 16'h0080, 8'b0000_0001, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
      add_vec(1'b1, 16'h6C00, 1'b1, 16'h0080, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b1, 16'h0080, 1'b1, 16'h6C00, 8'b0000_0000, 1'b1, 1'b0, 2'b00, 4'd3, 1'b0);
      add_vec(1'b1, 16'h0080, 1'b1, 16'h6C00, 8'b0000_0000, 1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
      add_vec(1'b1, 16'h0080, 1'b1, 16'h6C00, 8'b0000_1000, 1'b0, 1'b0, 2'b00, 4'd8, 1'b1);
      add_vec(1'b1, 16'h0080, 1'b1, 16'h6C00, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b1, 16'hE000, 1'b1, 16'h0080, 8'b0000_0001, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
      // reserved opcode: Done only
      add_vec(1'b1, 16'hE000, 1'b0, 16'h0080, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b0, 16'h0000, 1'b1, 16'hE000, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b1);
      // and R1,R0 with Run pulsed and DIN changing during T1-T3
      add_vec(1'b1, 16'h8400, 1'b0, 16'hE000, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b1, 16'hFFFF, 1'b0, 16'h8400, 8'b0000_0000, 1'b1, 1'b0, 2'b00, 4'd1, 1'b0);
      add_vec(1'b1, 16'h0D80, 1'b0, 16'h8400, 8'b0000_0000, 1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      add_vec(1'b1, 16'hFFFF, 1'b0, 16'h8400, 8'b0000_0010, 1'b0, 1'b0, 2'b00, 4'd8, 1'b1);
      add_vec(1'b0, 16'hFFFF, 1'b0, 16'h8400, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      // mv R3,R3 (Rx = Ry)
      add_vec(1'b1, 16'h0D80, 1'b0, 16'h8400, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
      add_vec(1'b0, 16'h0000, 1'b0, 16'h0D80, 8'b0000_1000, 1'b0, 1'b0, 2'b00, 4'd3, 1'b1);
      add_vec(1'b0, 16'h0000, 1'b0, 16'h0D80, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);

      // Reset state while Reset is still asserted
      #12;
      exp_q.push_back(idle(1'b0, 16'h0000, 16'h0000));
      check_outputs("reset_state");
      @(negedge Clock);
      Reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end

      // Reset asserted in the middle of T2 of add R2,R1
      begin
         vec_t v;
         v = idle(1'b1, 16'h4880, 16'h0D80);
         apply(v, "rst_seq_t0");
         v = idle(1'b0, 16'h0000, 16'h4880);
         v.ain = 1'b1; v.bs = 4'd2;
         apply(v, "rst_seq_t1");
         v = idle(1'b0, 16'h0000, 16'h4880);
         v.gin = 1'b1; v.bs = 4'd1;
         apply(v, "rst_seq_t2");
         #2;
         Reset = 1'b1;
         #1;
         exp_q.push_back(idle(1'b0, 16'h0000, 16'h0000));
         check_outputs("rst_async");
         @(negedge Clock);
         Reset = 1'b0;
         for (int k = 0; k < 3; k++) begin
            apply(idle(1'b0, 16'h0000, 16'h0000), $sformatf("rst_after%0d", k));
         end
      end

      // Latency of sub R3,R0: Done must appear in the 4th cycle
      @(negedge Clock);
      Run = 1'b1;
      DIN = 16'h6C00;
      cyc = 1;
      seen = 1'b0;
      while (cyc <= 10 && !seen) begin
         #1;
         if (Done === 1'b1) begin
            seen = 1'b1;
         end else begin
            @(negedge Clock);
            Run = 1'b0;
            cyc++;
         end
      end
      n_checks++;
      if (seen && cyc == 4) begin
         n_pass++;
      end else if (!seen) begin
         $display("FAIL sub_latency: Done not seen within 10 cycles, expected at cycle 4");
      end else begin
         $display("FAIL sub_latency: Done at cycle %0d, expected cycle 4", cyc);
      end

      // Done must drop again the cycle after
      @(negedge Clock);
      exp_q.push_back(idle(1'b0, 16'h6C00, 16'h6C00));
      #1;
      check_outputs("sub_done_drop");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
